// File: rtl/usb_tx_phy_gen.sv
// usb_tx_phy_gen: UTMI-to-transceiver USB transmit serializer.
// Emits SYNC, bit-stuffed NRZI data and EOP, with per-packet abort and a busy flag.
module usb_tx_phy_gen #(
   parameter int DATA_W    = 8,
   parameter int STUFF_LEN = 6,
   parameter int SYNC_BITS = 8,
   parameter int EOP_BITS  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fs_ce,
   input  logic              phy_mode,
   input  logic [DATA_W-1:0] DataOut_i,
   input  logic              TxValid_i,
   input  logic              TxValidH_i,
   input  logic              tx_abort_i,
   output logic              TxReady_o,
   output logic              txdp,
   output logic              txdn,
   output logic              txoe,
   output logic              tx_busy_o
);

   localparam int M1      = (SYNC_BITS > DATA_W) ? SYNC_BITS : DATA_W;
   localparam int M2      = (M1 > STUFF_LEN + 1) ? M1 : STUFF_LEN + 1;
   localparam int CNT_MAX = (M2 > EOP_BITS) ? M2 : EOP_BITS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int ONE_W   = $clog2(STUFF_LEN + 1);

   localparam logic [CNT_W-1:0] C_SYNC  = CNT_W'(SYNC_BITS);
   localparam logic [CNT_W-1:0] C_EOP   = CNT_W'(EOP_BITS);
   localparam logic [CNT_W-1:0] C_ERR   = CNT_W'(STUFF_LEN + 1);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [ONE_W-1:0] C_STUFF = ONE_W'(STUFF_LEN);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SYNC     = 3'd1,
      S_DATA     = 3'd2,
      S_STUFFERR = 3'd3,
      S_EOP      = 3'd4,
      S_IDLE_J   = 3'd5,
      S_REL      = 3'd6
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_dec, w_len;
   logic [ONE_W-1:0]  r_ones, w_ones_nxt;
   logic [DATA_W-1:0] r_shift;
   logic              r_lvl, r_txdp, r_txdn, r_txoe, r_ready, r_busy;
   logic              w_in_bits, w_abort, w_stuff, w_bit, w_tx_bit, w_word_end, w_load;
   logic              w_lvl_n, w_txoe_n, w_ready_n, w_busy_n;
   logic [1:0]        w_pins_n;

   // {txdp, txdn} for a line level (1 = J) or SE0 in the selected transceiver mode
   function automatic logic [1:0] line_pins(input logic lvl, input logic se0, input logic mode);
      logic [1:0] p;
      if (se0) p = mode ? 2'b00 : 2'b11;
      else     p = {lvl, mode ? ~lvl : 1'b0};
      return p;
   endfunction

   // Bit-slot decode: stuffing, word-end detection and load point
   always_comb begin
      w_in_bits  = (r_state == S_SYNC) || (r_state == S_DATA);
      w_abort    = tx_abort_i && w_in_bits;
      w_stuff    = (r_ones == C_STUFF);
      w_bit      = (r_state == S_SYNC) ? (r_cnt == C_ONE) : r_shift[0];
      w_tx_bit   = w_stuff ? 1'b0 : w_bit;
      w_ones_nxt = w_tx_bit ? (r_ones + ONE_W'(1)) : {ONE_W{1'b0}};
      w_cnt_dec  = w_stuff ? r_cnt : (r_cnt - C_ONE);
      w_word_end = (w_cnt_dec == {CNT_W{1'b0}}) && (w_ones_nxt != C_STUFF);
      w_load     = fs_ce && w_in_bits && !w_abort && w_word_end;
      w_len      = ((DATA_W > 8) && TxValidH_i) ? CNT_W'(DATA_W) : CNT_W'(8);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; abort outranks a word load on the same edge
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     w_state_nxt = TxValid_i ? S_SYNC : S_IDLE;
         S_SYNC, S_DATA: begin
            if (w_abort)                 w_state_nxt = S_STUFFERR;
            else if (fs_ce && w_word_end) w_state_nxt = TxValid_i ? S_DATA : S_EOP;
            else                          w_state_nxt = r_state;
         end
         S_STUFFERR: w_state_nxt = (fs_ce && r_cnt == C_ONE) ? S_EOP : S_STUFFERR;
         S_EOP:      w_state_nxt = (fs_ce && r_cnt == C_ONE) ? S_IDLE_J : S_EOP;
         S_IDLE_J:   w_state_nxt = fs_ce ? S_REL : S_IDLE_J;
         S_REL:      w_state_nxt = fs_ce ? S_IDLE : S_REL;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: next pin values, NRZI level, handshake and busy
   always_comb begin
      w_lvl_n   = r_lvl;
      w_pins_n  = {r_txdp, r_txdn};
      w_txoe_n  = r_txoe;
      w_ready_n = w_load && TxValid_i;
      w_busy_n  = (w_state_nxt != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (TxValid_i) w_lvl_n = 1'b1;
            else           w_lvl_n = r_lvl;
         end
         S_SYNC, S_DATA: begin
            if (fs_ce && !w_abort) begin
               w_lvl_n  = w_tx_bit ? r_lvl : ~r_lvl;
               w_pins_n = line_pins(w_lvl_n, 1'b0, phy_mode);
               w_txoe_n = 1'b0;
            end else begin
               w_txoe_n = r_txoe;
            end
         end
         S_STUFFERR: begin
            if (fs_ce) begin
               w_pins_n = line_pins(r_lvl, 1'b0, phy_mode);
               w_txoe_n = 1'b0;
            end else begin
               w_txoe_n = r_txoe;
            end
         end
         S_EOP: begin
            if (fs_ce) begin
               w_pins_n = line_pins(1'b1, 1'b1, phy_mode);
               w_txoe_n = 1'b0;
            end else begin
               w_txoe_n = r_txoe;
            end
         end
         S_IDLE_J, S_REL: begin
            if (fs_ce) begin
               w_lvl_n  = 1'b1;
               w_pins_n = line_pins(1'b1, 1'b0, phy_mode);
               w_txoe_n = (r_state == S_REL);
            end else begin
               w_txoe_n = r_txoe;
            end
         end
         default: w_lvl_n = r_lvl;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= {CNT_W{1'b0}};
         r_ones  <= {ONE_W{1'b0}};
         r_shift <= {DATA_W{1'b0}};
         r_lvl   <= 1'b1;
         r_txdp  <= 1'b1;
         r_txdn  <= 1'b0;
         r_txoe  <= 1'b1;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_lvl   <= w_lvl_n;
         r_txdp  <= w_pins_n[1];
         r_txdn  <= w_pins_n[0];
         r_txoe  <= w_txoe_n;
         r_ready <= w_ready_n;
         r_busy  <= w_busy_n;
         case (r_state)
            S_IDLE: begin
               if (TxValid_i) begin
                  r_cnt  <= C_SYNC;
                  r_ones <= {ONE_W{1'b0}};
               end
            end
            S_SYNC, S_DATA: begin
               if (w_abort) begin
                  r_cnt <= C_ERR;
               end else if (fs_ce) begin
                  r_ones <= w_ones_nxt;
                  if (!w_stuff) r_shift <= r_shift >> 1;
                  if (w_word_end) begin
                     if (TxValid_i) begin
                        r_shift <= DataOut_i;
                        r_cnt   <= w_len;
                     end else begin
                        r_cnt <= C_EOP;
                     end
                  end else begin
                     r_cnt <= w_cnt_dec;
                  end
               end
            end
            S_STUFFERR: if (fs_ce) r_cnt <= (r_cnt == C_ONE) ? C_EOP : (r_cnt - C_ONE);
            S_EOP:      if (fs_ce) r_cnt <= r_cnt - C_ONE;
            default:    r_cnt <= r_cnt;
         endcase
      end
   end

   assign TxReady_o = r_ready;
   assign txdp      = r_txdp;
   assign txdn      = r_txdn;
   assign txoe      = r_txoe;
   assign tx_busy_o = r_busy;

endmodule

// File: tb/tb_usb_tx_phy_gen.sv
// Self-checking bench for usb_tx_phy_gen: a packet-level model expands each packet into
// its expected per-tick line sequence, and a compare process checks the pins every clock.
module tb_usb_tx_phy_gen;
   localparam int DW = 16, SL = 6, SB = 8, EB = 2;

   logic clk = 1'b0;
   logic rst = 1'b1, fs_ce = 1'b0, phy_mode = 1'b1;
   logic txvalid = 1'b0, txvalidh = 1'b0, abort = 1'b0;
   logic [DW-1:0] dout = '0;
   logic txready, txdp, txdn, txoe, busy;

   usb_tx_phy_gen #(.DATA_W(DW), .STUFF_LEN(SL), .SYNC_BITS(SB), .EOP_BITS(EB)) dut (
      .clk(clk), .rst(rst), .fs_ce(fs_ce), .phy_mode(phy_mode), .DataOut_i(dout),
      .TxValid_i(txvalid), .TxValidH_i(txvalidh), .tx_abort_i(abort),
      .TxReady_o(txready), .txdp(txdp), .txdn(txdn), .txoe(txoe), .tx_busy_o(busy));

   always #5 clk = ~clk;

   // one line bit time: SE0 flag, level (1 = J), txoe value, TxReady expected on this tick
   typedef struct packed { logic se0; logic lvl; logic oe; logic rdy; } el_t;
   localparam el_t IDLE_EL = el_t'(4'b0110);

   el_t         exq[$];
   el_t         cur = IDLE_EL;
   logic        exp_rdy = 1'b0;
   int          ndata = 0, popped = 0;
   bit          active = 1'b0, aborted = 1'b0;
   logic [DW-1:0] pw[$];
   bit          ph[$];
   int          checks = 0, fails = 0;
   int          ce_mode = 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] pins_of(input el_t e, input logic mode);
      if (e.se0) return mode ? 2'b00 : 2'b11;
      return {e.lvl, mode ? ~e.lvl : 1'b0};
   endfunction

   function automatic void push_tail();
      for (int i = 0; i < EB; i++) exq.push_back(el_t'(4'b1100));
      exq.push_back(el_t'(4'b0100));
      exq.push_back(el_t'(4'b0110));
   endfunction

   // expand the packet in pw/ph into the expected line sequence
   function automatic void build();
      bit raw[$];
      bit isend[$];
      int ones;
      logic lvl;
      el_t e;
      exq.delete();
      for (int i = 0; i < SB; i++) begin
         raw.push_back(i == SB - 1);
         isend.push_back(i == SB - 1);
      end
      for (int w = 0; w < pw.size(); w++) begin
         int len;
         len = ph[w] ? 16 : 8;
         for (int b = 0; b < len; b++) begin
            raw.push_back(pw[w][b]);
            isend.push_back((b == len - 1) && (w < pw.size() - 1));
         end
      end
      ones = 0;
      lvl  = 1'b1;
      for (int r = 0; r < raw.size(); r++) begin
         if (!raw[r]) lvl = ~lvl;
         e = '0; e.lvl = lvl; exq.push_back(e);
         ones = raw[r] ? ones + 1 : 0;
         if (ones == SL) begin
            lvl = ~lvl;
            e = '0; e.lvl = lvl; exq.push_back(e);
            ones = 0;
         end
         if (isend[r]) begin
            e = exq.pop_back(); e.rdy = 1'b1; exq.push_back(e);
         end
      end
      ndata = exq.size();
      push_tail();
   endfunction

   function automatic void do_abort();
      el_t e;
      e = '0; e.lvl = cur.lvl;
      exq.delete();
      for (int i = 0; i <= SL; i++) exq.push_back(e);
      push_tail();
      aborted = 1'b1;
   endfunction

   function automatic int rdy_idx(input int k);
      int n;
      n = 0;
      for (int i = 0; i < exq.size(); i++)
         if (exq[i].rdy) begin
            if (n == k) return i;
            n++;
         end
      return -1;
   endfunction

   // model step on every edge, then compare all outputs just after it
   always @(posedge clk) begin
      logic [1:0] p;
      exp_rdy = 1'b0;
      if (rst) begin
         active = 1'b0; exq.delete(); cur = IDLE_EL;
      end else if (!active) begin
         if (txvalid) begin
            build(); active = 1'b1; popped = 0; aborted = 1'b0;
         end
      end else if (abort && !aborted && popped < ndata) begin
         do_abort();
      end else if (fs_ce) begin
         if (exq.size() == 0) begin
            chk("queue_underrun", 32'd1, 32'd0);
            active = 1'b0;
         end else begin
            cur = exq.pop_front();
            popped++;
            exp_rdy = cur.rdy;
            if (exq.size() == 0) active = 1'b0;
         end
      end
      #1;
      p = pins_of(cur, phy_mode);
      chk("txdp", txdp, p[1]);
      chk("txdn", txdn, p[0]);
      chk("txoe", txoe, cur.oe);
      chk("TxReady", txready, exp_rdy);
      chk("busy", busy, active);
   end

   always @(negedge clk) begin
      case (ce_mode)
         0:       fs_ce = ($urandom_range(0, 2) == 0);
         1:       fs_ce = 1'b1;
         default: fs_ce = 1'b0;
      endcase
   end

   task automatic send_pkt(input bit mode, input int abort_at, input int freeze_at,
                           input int rst_at, input int cem);
      int idx, cyc;
      bit done;
      phy_mode = mode; ce_mode = cem;
      idx = 0; dout = pw[0]; txvalidh = ph[0]; txvalid = 1'b1; abort = 1'b0;
      cyc = 0; done = 1'b0;
      while (!done && cyc < 3000) begin
         @(posedge clk); #1;
         abort = 1'b0;
         if (txready) begin
            idx++;
            if (idx < pw.size()) begin dout = pw[idx]; txvalidh = ph[idx]; end
            else txvalid = 1'b0;
         end
         if (cyc == abort_at) begin abort = 1'b1; txvalid = 1'b0; end
         if (cyc == freeze_at) ce_mode = 2;
         if (cyc == freeze_at + 24) ce_mode = cem;
         if (cyc == rst_at) begin
            #2 rst = 1'b1; #1;
            chk("rst_txdp", txdp, 32'd1);
            chk("rst_txdn", txdn, 32'd0);
            chk("rst_txoe", txoe, 32'd1);
            chk("rst_busy", busy, 32'd0);
            chk("rst_ready", txready, 32'd0);
            txvalid = 1'b0;
            @(posedge clk); @(posedge clk); #3 rst = 1'b0;
            done = 1'b1;
         end
         if (cyc > 0 && !busy && !txvalid) done = 1'b1;
         cyc++;
      end
      if (!done) chk("pkt_timeout", 32'd0, 32'd1);
      abort = 1'b0; txvalid = 1'b0; ce_mode = cem;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic set1(input logic [15:0] w0, input bit h0);
      pw.delete(); ph.delete(); pw.push_back(w0); ph.push_back(h0);
   endtask

   task automatic set2(input logic [15:0] w0, input bit h0, input logic [15:0] w1, input bit h1);
      set1(w0, h0); pw.push_back(w1); ph.push_back(h1);
   endtask

   initial begin
      logic [15:0] v;
      int tog;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_txdp", txdp, 32'd1);
      chk("reset_txdn", txdn, 32'd0);
      chk("reset_txoe", txoe, 32'd1);
      chk("reset_busy", busy, 32'd0);
      chk("reset_ready", txready, 32'd0);
      @(negedge clk) rst = 1'b0;

      // hand-computed pins of the model: one 0x00 byte is KJKJKJKK JKJKJKJK
      set1(16'h0000, 1'b0); build();
      for (int i = 0; i < 16; i++) v[15-i] = exq[i].lvl;
      chk("model_sync00_lvl", v, 32'h54AA);
      for (int i = 0; i < 16; i++) v[15-i] = exq[i].rdy;
      chk("model_sync00_rdy", v, 32'h0100);
      chk("model_sync00_len", exq.size(), 32'd20);
      set2(16'h00FF, 1'b0, 16'h00FF, 1'b0); build();
      chk("model_ff_ndata", ndata, 32'd26);
      chk("model_ff_rdy0", rdy_idx(0), 32'd7);
      chk("model_ff_rdy1", rdy_idx(1), 32'd16);
      tog = 0;
      for (int i = 8; i < ndata; i++) if (exq[i].lvl != exq[i-1].lvl) tog++;
      chk("model_ff_stuffs", tog, 32'd2);
      set2(16'h1234, 1'b1, 16'h00AB, 1'b0); build();
      chk("model_w16_ndata", ndata, 32'd32);
      chk("model_w16_rdy_gap", rdy_idx(1) - rdy_idx(0), 32'd16);
      exq.delete();

      set1(16'h0000, 1'b0);                     send_pkt(1'b1, -1, -1, -1, 1);
      set2(16'h00FF, 1'b0, 16'h00FF, 1'b0);     send_pkt(1'b1, -1, -1, -1, 0);
      set2(16'h1234, 1'b1, 16'h00AB, 1'b0);     send_pkt(1'b1, -1, -1, -1, 0);
      set2(16'h00FC, 1'b0, 16'h0001, 1'b0);     send_pkt(1'b1, -1, -1, -1, 1);
      set1(16'h00A5, 1'b0);                     send_pkt(1'b1, 12, -1, -1, 1);
      set2(16'h00FF, 1'b0, 16'h00FF, 1'b0);     send_pkt(1'b1, -1, -1, 14, 1);
      set1(16'h0000, 1'b0);                     send_pkt(1'b1, -1, -1, -1, 1);
      set1(16'h005A, 1'b0);                     send_pkt(1'b0, -1, 10, -1, 0);
      set1(16'hFFFF, 1'b1);                     send_pkt(1'b0, 3, -1, -1, 1);

      for (int p = 0; p < 40; p++) begin
         int nw;
         nw = $urandom_range(1, 3);
         pw.delete(); ph.delete();
         for (int w = 0; w < nw; w++) begin
            pw.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
            ph.push_back(1'($urandom));
         end
         send_pkt(1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : -1,
                  ($urandom_range(0, 5) == 0) ? $urandom_range(2, 30) : -1, -1,
                  $urandom_range(0, 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
